rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
Four-requester round-robin arbiter that shares one downstream resource (a bus or datapath port) between requesters 0..3. It issues a registered one-hot grant plus an encoded grant index. It holds the grant until the owner releases it or a hold timeout expires. Selection reuses the team's 4-to-2 priority encoder on a rotated request vector.

Parameters:
MAX_HOLD, 16, max cycles a grant may be held before forced release; 0 disables timeout
CNT_W, 5, hold-counter width; must satisfy 2**CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
enable  input  1  arbitration enable; gates new grants only
req  input  4  request per requester, level, held until served
done  input  1  owner releases resource (sampled only in BUSY)
gnt  output  4  one-hot grant, registered
gnt_id  output  2  index of current/last grant
gnt_valid  output  1  =|gnt
timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst_n=0, async): state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0, last=3. With last=3, requester 0 has top priority first.
- Priority order after last grant k: k+1, k+2, k+3, k (mod 4).
- Winner calc: rotate req right by (last+1) mod 4, bit-reverse, feed the encoder, then de-rotate. Equivalent result: first set bit of req scanning up from last+1 with wrap-around.
- States: IDLE, BUSY, RELEASE.
- IDLE: if enable && |req, go to BUSY next edge with gnt=onehot(winner), gnt_id=winner, last=winner, hold_cnt=0. Otherwise stay, gnt=0.
- Latency: req sampled at edge N gives gnt visible after edge N (1 cycle).
- BUSY: hold_cnt increments every cycle, saturating.
- BUSY release condition, evaluated each cycle:
  - (a) done=1, or
  - (b) req[gnt_id]=0, or
  - (c) MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1.
- On release, go to RELEASE next edge with gnt=0 and gnt_valid=0. gnt_id keeps its value.
- timeout=1 for exactly the RELEASE cycle entered via (c) only. If (a) or (b) occurs in the same cycle as (c), timeout=0.
- RELEASE lasts 1 cycle. It arbitrates identically to IDLE, so the next grant comes at the following edge; a minimum gap of 1 idle-grant cycle always exists between owners. If there is no request or enable=0, go to IDLE.
- enable=0 during BUSY does not revoke the current grant. It only blocks the next one.
- Requests from non-owners during BUSY are ignored until RELEASE. No preemption.
- A timed-out owner still asserting req is re-eligible but has lowest priority, since last=its id.
- Single continuous requester with MAX_HOLD=M: pattern repeats M grant cycles, 1 gap cycle.
- done with no grant (IDLE/RELEASE) is ignored.
- Reset mid-BUSY: gnt drops asynchronously, and the priority pointer returns to last=3.
- Invariants: gnt is always one-hot or zero; gnt_valid==|gnt; gnt[gnt_id]==1 whenever gnt_valid.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2), N_REQ=4, and default MAX_HOLD.
- Sub-module: instantiate the existing priority_encoder_4_to_2 (enable, in[3:0], out[1:0], valid) as the selection core.
  - Arbiter contains rotation/de-rotation logic, FSM, hold counter, pointer.
  - Encoder enable tied to the arbiter enable.
  - The encoder's valid output serves as the "any request" term.

Test Plan:
- Reset, then req=4'b1111 held, done pulsed 1 cycle after each grant -> gnt sequence 0001, 0010, 0100, 1000, 0001, with a 1-cycle gap (gnt=0) between each and gnt_id 0,1,2,3,0.
- req=4'b0100 only, held; MAX_HOLD=16 -> gnt=0100 for 16 cycles, then timeout=1 with gnt=0 for 1 cycle, regranted the next cycle; repeats.
- Owner 1 granted, then req=4'b1011 arrives while BUSY; owner drops req[1] -> RELEASE, then grant to 3 (next after 1), then 0, then 1.
- enable=0 with req=4'b0010 -> gnt stays 0. Raise enable -> gnt=0010 one cycle later. Drop enable mid-grant -> grant held until done.
- rst_n asserted asynchronously mid-BUSY (gnt=1000) -> gnt=0 immediately without a clock edge. After release with req=4'b1001, the grant goes to 0, proving last=3.
- done and hold-timeout in the same cycle -> release occurs with timeout=0; done while IDLE -> no state change.

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// ----------------------------------------------------------------------------
// rr_arbiter_4_pkg
// Shared definitions for the four-requester round-robin arbiter:
//   - state_t          : arbiter FSM state encoding
//   - N_REQ            : number of requesters
//   - DEFAULT_MAX_HOLD : default grant hold limit in cycles (0 = no limit)
//   - DEFAULT_CNT_W    : default hold-counter width
//   - onehot4()        : converts a 2-bit index into a one-hot grant vector
// ----------------------------------------------------------------------------
package rr_arbiter_4_pkg;

    localparam int N_REQ            = 4;
    localparam int DEFAULT_MAX_HOLD = 16;
    localparam int DEFAULT_CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_encoder.sv
// ----------------------------------------------------------------------------
// priority_encoder_4_to_2
// Four-input priority encoder; the highest-numbered set input wins.
// Ports:
//   enable : when low, out=0 and valid=0 regardless of in
//   in     : request vector, bit 3 has the highest priority
//   out    : index of the winning input
//   valid  : at least one input set while enabled
// ----------------------------------------------------------------------------
module priority_encoder_4_to_2 (
    input  logic       enable,
    input  logic [3:0] in,
    output logic [1:0] out,
    output logic       valid
);

    always_comb begin
        out   = 2'd0;
        valid = 1'b0;
        if (enable) begin
            valid = |in;
            if (in[3])      out = 2'd3;
            else if (in[2]) out = 2'd2;
            else if (in[1]) out = 2'd1;
            else            out = 2'd0;
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// ----------------------------------------------------------------------------
// rr_arbiter_4
// Round-robin arbiter sharing one downstream resource among four requesters.
// A grant is held until the owner signals done, drops its request, or the
// hold limit expires. Owners are always separated by one gap cycle.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   enable    : allows new grants; never revokes an existing one
//   req[3:0]  : level requests, held until served
//   done      : owner releases the resource (only meaningful while granted)
//   gnt[3:0]  : registered one-hot grant
//   gnt_id    : index of the current or most recent grant
//   gnt_valid : high whenever gnt is non-zero
//   timeout   : one-cycle pulse when a grant was forcibly released
// ----------------------------------------------------------------------------
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);
    localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);

    state_t           state;
    logic [1:0]       last;
    logic [CNT_W-1:0] hold_cnt;

    logic [1:0]       shift;
    logic [3:0]       rotated;
    logic [3:0]       reversed;
    logic [1:0]       enc_out;
    logic             any_req;
    logic [1:0]       winner;
    logic             owner_release;
    logic             hold_expired;

    // Rotate the request vector so the requester just after the last owner
    // lands in bit 0, then bit-reverse it so that requester becomes the
    // encoder's highest-priority input.
    always_comb begin
        shift   = last + 2'd1;
        rotated = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rotated[i] = req[2'(i) + shift];
        end
        reversed = {rotated[0], rotated[1], rotated[2], rotated[3]};
    end

    priority_encoder_4_to_2 u_encoder (
        .enable (enable),
        .in     (reversed),
        .out    (enc_out),
        .valid  (any_req)
    );

    // Undo the bit reversal (3 - out) and the rotation (+ shift); both wrap
    // naturally in two bits.
    always_comb begin
        winner = (2'd3 - enc_out) + shift;
    end

    // Release causes while an owner holds the grant. A voluntary release in
    // the same cycle as the hold limit takes precedence, so no timeout pulse.
    always_comb begin
        owner_release = done || !req[gnt_id];
        hold_expired  = TIMEOUT_EN && (hold_cnt == HOLD_LAST);
    end

    // Arbiter FSM with registered grant outputs, hold counter and the
    // round-robin pointer. RELEASE arbitrates exactly like IDLE, so a waiting
    // requester is granted right after the single gap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            last      <= 2'd3;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, RELEASE: begin
                    if (any_req) begin
                        state     <= BUSY;
                        gnt       <= onehot4(winner);
                        gnt_id    <= winner;
                        gnt_valid <= 1'b1;
                        last      <= winner;
                        hold_cnt  <= '0;
                    end else begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (owner_release || hold_expired) begin
                        state     <= RELEASE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        timeout   <= hold_expired && !owner_release;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter_4
// Directed self-checking bench for rr_arbiter_4 (MAX_HOLD=16).
// ----------------------------------------------------------------------------
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp;
    int n_fail;

    rr_arbiter_4 #(
        .MAX_HOLD (16),
        .CNT_W    (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = 4'b0000;
        done   = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b want 0000", gnt); end
        n_cmp++;
        if (gnt_id !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_gnt_id: got %0d want 0", gnt_id); end
        n_cmp++;
        if (gnt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_gnt_valid: got %b want 0", gnt_valid); end
        n_cmp++;
        if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout); end
    endtask

    // All four requesting, done pulsed after each grant.
    task automatic test_round_robin();
        logic [1:0] exp_ids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_gnt = 4'b0001 << exp_ids[k];
            n_cmp++;
            if (gnt !== exp_gnt) begin n_fail++; $display("[TB] FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_gnt); end
            n_cmp++;
            if (gnt_id !== exp_ids[k]) begin n_fail++; $display("[TB] FAIL rr_gnt_id[%0d]: got %0d want %0d", k, gnt_id, exp_ids[k]); end
            n_cmp++;
            if (gnt_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rr_valid[%0d]: got %b want 1", k, gnt_valid); end
            done = 1'b1;
            tick();
            done = 1'b0;
            n_cmp++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_gap[%0d]: gnt=%b valid=%b want 0000/0", k, gnt, gnt_valid); end
            n_cmp++;
            if (gnt_id !== exp_ids[k] || timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_gap_id[%0d]: id=%0d to=%b want %0d/0", k, gnt_id, timeout, exp_ids[k]); end
        end
        req = 4'b0000;
        tick();
    endtask

    // Single requester held forever: 16 grant cycles, 1 timeout gap, repeat.
    task automatic test_timeout();
        do_reset();
        req = 4'b0100;
        tick();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 16; c++) begin
                n_cmp++;
                if (gnt !== 4'b0100 || timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL to_hold[%0d][%0d]: gnt=%b to=%b want 0100/0", r, c, gnt, timeout); end
                tick();
            end
            n_cmp++;
            if (gnt !== 4'b0000 || timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL to_pulse[%0d]: gnt=%b to=%b want 0000/1", r, gnt, timeout); end
            n_cmp++;
            if (gnt_id !== 2'd2) begin n_fail++; $display("[TB] FAIL to_id[%0d]: got %0d want 2", r, gnt_id); end
            tick();
        end
        n_cmp++;
        if (gnt !== 4'b0100 || timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL to_regrant: gnt=%b to=%b want 0100/0", gnt, timeout); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // Requests arriving during BUSY never preempt the owner.
    task automatic test_no_preempt();
        do_reset();
        req = 4'b0010;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin n_fail++; $display("[TB] FAIL np_first: got %b want 0010", gnt); end
        req = 4'b1011;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin n_fail++; $display("[TB] FAIL np_hold: got %b want 0010", gnt); end
        req = 4'b1001;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL np_drop: gnt=%b to=%b want 0000/0", gnt, timeout); end
        tick();
        n_cmp++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin n_fail++; $display("[TB] FAIL np_to3: gnt=%b id=%0d want 1000/3", gnt, gnt_id); end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin n_fail++; $display("[TB] FAIL np_to0: gnt=%b id=%0d want 0001/0", gnt, gnt_id); end
        req  = 4'b1011;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin n_fail++; $display("[TB] FAIL np_to1: gnt=%b id=%0d want 0010/1", gnt, gnt_id); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // enable gates new grants only.
    task automatic test_enable();
        do_reset();
        enable = 1'b0;
        req    = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL en_off[%0d]: gnt=%b valid=%b want 0000/0", c, gnt, gnt_valid); end
        end
        enable = 1'b1;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010 || gnt_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL en_on: gnt=%b valid=%b want 0010/1", gnt, gnt_valid); end
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0010) begin n_fail++; $display("[TB] FAIL en_keep[%0d]: got %b want 0010", c, gnt); end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++;
        if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL en_done: got %b want 0000", gnt); end
        tick();
        n_cmp++;
        if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL en_block: got %b want 0000", gnt); end
        req    = 4'b0000;
        enable = 1'b1;
        tick();
    endtask

    // Asynchronous reset while requester 3 owns the grant.
    task automatic test_async_reset();
        do_reset();
        req = 4'b1000;
        tick();
        n_cmp++;
        if (gnt !== 4'b1000) begin n_fail++; $display("[TB] FAIL ar_pre: got %b want 1000", gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_drop: gnt=%b valid=%b want 0000/0", gnt, gnt_valid); end
        #2;
        rst_n = 1'b1;
        req   = 4'b1001;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin n_fail++; $display("[TB] FAIL ar_ptr: gnt=%b id=%0d want 0001/0", gnt, gnt_id); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // done coincident with the hold limit, and done while idle.
    task automatic test_done_cases();
        do_reset();
        req = 4'b0001;
        tick();
        repeat (15) tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL dc_last: got %b want 0001", gnt); end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL dc_both: gnt=%b to=%b want 0000/0", gnt, timeout); end
        req = 4'b0000;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL dc_idle: gnt=%b valid=%b to=%b want 0000/0/0", gnt, gnt_valid, timeout); end
        req = 4'b0010;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin n_fail++; $display("[TB] FAIL dc_after: gnt=%b id=%0d want 0010/1", gnt, gnt_id); end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_round_robin();
        test_timeout();
        test_no_preempt();
        test_enable();
        test_async_reset();
        test_done_cases();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
